// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory-stage requesters onto one fixed-latency RAM port.
// Optional ARB_ROUND_ROBIN_EN alternates grants on contention; default is mem-over-fetch priority.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_w,
    input  logic [31:0] if_addr_w,
    output logic [31:0] if_rdata_l,
    output logic        if_ack_l,
    input  logic        mem_req_w,
    input  logic        mem_we_w,
    input  logic        mem_byte_w,
    input  logic [31:0] mem_addr_w,
    input  logic [31:0] mem_wdata_w,
    output logic [31:0] mem_rdata_l,
    output logic        mem_ack_l,
    output logic        ram_en_l,
    output logic        ram_we_l,
    output logic [3:0]  ram_wmask_l,
    output logic [31:0] ram_addr_l,
    output logic [31:0] ram_wdata_l,
    input  logic [31:0] ram_rdata_w,
    output logic        arb_busy_l
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        owner_mem;
    logic        lat_we;
    logic        lat_byte;
    logic [1:0]  lat_lane;
    logic        any_req;
    logic        grant_mem;
    logic        grant_store;
    logic        last_cnt;
    logic [31:0] sel_addr;
    logic [3:0]  wmask_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  load_byte;
    logic [31:0] load_data;

    assign any_req  = if_req_w | mem_req_w;
    assign last_cnt = (cnt == 4'd1);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_mem;

    // Contended grant goes to whichever port did not win last time.
    assign grant_mem = mem_req_w & (~if_req_w | ~last_grant_mem);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant_mem <= 1'b0;
        else if (state == IDLE && any_req)
            last_grant_mem <= grant_mem;
    end
`else
    assign grant_mem = mem_req_w;
`endif

    assign grant_store = grant_mem & mem_we_w;
    assign sel_addr    = grant_mem ? mem_addr_w : if_addr_w;

    always_comb begin
        wmask_nxt = 4'h0;
        wdata_nxt = 32'h0;
        if (grant_store) begin
            if (mem_byte_w) begin
                wmask_nxt = 4'b0001 << mem_addr_w[1:0];
                wdata_nxt = {4{mem_wdata_w[7:0]}};
            end else begin
                wmask_nxt = 4'hF;
                wdata_nxt = mem_wdata_w;
            end
        end
    end

    always_comb begin
        load_byte = ram_rdata_w[7:0];
        case (lat_lane)
            2'd1:    load_byte = ram_rdata_w[15:8];
            2'd2:    load_byte = ram_rdata_w[23:16];
            2'd3:    load_byte = ram_rdata_w[31:24];
            default: load_byte = ram_rdata_w[7:0];
        endcase
        load_data = lat_byte ? {{24{load_byte[7]}}, load_byte} : ram_rdata_w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (last_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign arb_busy_l = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 4'd0;
            owner_mem   <= 1'b0;
            lat_we      <= 1'b0;
            lat_byte    <= 1'b0;
            lat_lane    <= 2'd0;
            if_rdata_l  <= 32'h0;
            mem_rdata_l <= 32'h0;
            if_ack_l    <= 1'b0;
            mem_ack_l   <= 1'b0;
            ram_en_l    <= 1'b0;
            ram_we_l    <= 1'b0;
            ram_wmask_l <= 4'h0;
            ram_addr_l  <= 32'h0;
            ram_wdata_l <= 32'h0;
        end else begin
            if_ack_l  <= 1'b0;
            mem_ack_l <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_mem   <= grant_mem;
                        lat_we      <= grant_store;
                        lat_byte    <= grant_mem & mem_byte_w;
                        lat_lane    <= sel_addr[1:0];
                        cnt         <= 4'(MEM_LATENCY);
                        ram_en_l    <= 1'b1;
                        ram_we_l    <= grant_store;
                        ram_wmask_l <= wmask_nxt;
                        ram_addr_l  <= sel_addr & ~32'h3;
                        ram_wdata_l <= wdata_nxt;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (last_cnt) begin
                        ram_en_l    <= 1'b0;
                        ram_we_l    <= 1'b0;
                        ram_wmask_l <= 4'h0;
                        ram_addr_l  <= 32'h0;
                        ram_wdata_l <= 32'h0;
                        if (owner_mem) begin
                            mem_ack_l <= 1'b1;
                            if (!lat_we)
                                mem_rdata_l <= load_data;
                        end else begin
                            if_ack_l   <= 1'b1;
                            if_rdata_l <= ram_rdata_w;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, contention, reset-abort, random traffic and a MEM_LATENCY=1 instance.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_w, mem_req_w, mem_we_w, mem_byte_w;
    logic [31:0] if_addr_w, mem_addr_w, mem_wdata_w;
    logic [31:0] if_rdata_l, mem_rdata_l, ram_addr_l, ram_wdata_l, ram_rdata_w;
    logic        if_ack_l, mem_ack_l, ram_en_l, ram_we_l, arb_busy_l;
    logic [3:0]  ram_wmask_l;

    logic        d1_if_req, d1_mem_req, d1_mem_we, d1_mem_byte;
    logic [31:0] d1_if_addr, d1_mem_addr, d1_mem_wdata;
    logic [31:0] d1_if_rdata, d1_mem_rdata, d1_ram_addr, d1_ram_wdata, d1_ram_rdata;
    logic        d1_if_ack, d1_mem_ack, d1_ram_en, d1_ram_we, d1_busy;
    logic [3:0]  d1_ram_wmask;

    logic [31:0] rmem [0:255];
    logic [31:0] gmem [0:255];
    logic [31:0] m_if_rdata, m_mem_rdata;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    assign ram_rdata_w  = rmem[ram_addr_l[9:2]];
    assign d1_ram_rdata = d1_ram_addr ^ 32'hA5A50000;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .if_req_w(if_req_w), .if_addr_w(if_addr_w), .if_rdata_l(if_rdata_l), .if_ack_l(if_ack_l),
        .mem_req_w(mem_req_w), .mem_we_w(mem_we_w), .mem_byte_w(mem_byte_w),
        .mem_addr_w(mem_addr_w), .mem_wdata_w(mem_wdata_w), .mem_rdata_l(mem_rdata_l), .mem_ack_l(mem_ack_l),
        .ram_en_l(ram_en_l), .ram_we_l(ram_we_l), .ram_wmask_l(ram_wmask_l), .ram_addr_l(ram_addr_l),
        .ram_wdata_l(ram_wdata_l), .ram_rdata_w(ram_rdata_w), .arb_busy_l(arb_busy_l)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req_w(d1_if_req), .if_addr_w(d1_if_addr), .if_rdata_l(d1_if_rdata), .if_ack_l(d1_if_ack),
        .mem_req_w(d1_mem_req), .mem_we_w(d1_mem_we), .mem_byte_w(d1_mem_byte),
        .mem_addr_w(d1_mem_addr), .mem_wdata_w(d1_mem_wdata), .mem_rdata_l(d1_mem_rdata), .mem_ack_l(d1_mem_ack),
        .ram_en_l(d1_ram_en), .ram_we_l(d1_ram_we), .ram_wmask_l(d1_ram_wmask), .ram_addr_l(d1_ram_addr),
        .ram_wdata_l(d1_ram_wdata), .ram_rdata_w(d1_ram_rdata), .arb_busy_l(d1_busy)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Transaction-level reference: memory image plus the two read-data registers.
    task automatic model_apply(input bit is_mem, input bit we, input bit byt,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [3:0] em, output logic [31:0] ew);
        int idx;
        int lane;
        logic [31:0] w;
        logic [7:0]  b;
        idx  = int'(addr[9:2]);
        lane = int'(addr[1:0]);
        em   = 4'h0;
        ew   = 32'h0;
        w    = gmem[idx];
        if (is_mem && we) begin
            if (byt) begin
                em = 4'b0001 << lane;
                ew = {4{wdata[7:0]}};
                w[lane*8 +: 8] = wdata[7:0];
            end else begin
                em = 4'hF;
                ew = wdata;
                w  = wdata;
            end
            gmem[idx] = w;
        end else if (!is_mem) begin
            m_if_rdata = w;
        end else if (byt) begin
            b = w[lane*8 +: 8];
            m_mem_rdata = {{24{b[7]}}, b};
        end else begin
            m_mem_rdata = w;
        end
    endtask

    // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
    task automatic xact(input bit is_mem, input bit we, input bit byt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] em, input logic [31:0] ew, input logic [31:0] er);
        int k;
        int en_n;
        bit addr_ok;
        bit got;
        logic [31:0] ea;
        logic [31:0] w;
        ea = {addr[31:2], 2'b00};
        if (is_mem) begin
            mem_req_w = 1'b1; mem_we_w = we; mem_byte_w = byt;
            mem_addr_w = addr; mem_wdata_w = wdata;
        end else begin
            if_req_w = 1'b1; if_addr_w = addr;
        end
        @(posedge clk); #1;
        chk("grant_ram_en", 32'(ram_en_l), 32'd1);
        chk("grant_busy", 32'(arb_busy_l), 32'd1);
        chk("ram_addr", ram_addr_l, ea);
        chk("ram_we", 32'(ram_we_l), 32'(is_mem & we));
        chk("ram_wmask", 32'(ram_wmask_l), 32'(em));
        if (is_mem && we) chk("ram_wdata", ram_wdata_l, ew);
        en_n = 0; addr_ok = 1'b1; got = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (if_ack_l || mem_ack_l) begin
                got = 1'b1;
                break;
            end
            if (ram_en_l) begin
                en_n++;
                if (ram_addr_l !== ea) addr_ok = 1'b0;
                if (ram_we_l) begin
                    w = rmem[ram_addr_l[9:2]];
                    for (int b = 0; b < 4; b++)
                        if (ram_wmask_l[b]) w[b*8 +: 8] = ram_wdata_l[b*8 +: 8];
                    rmem[ram_addr_l[9:2]] = w;
                end
            end
            @(posedge clk); #1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", 32'(k), 32'(L));
        chk("en_cycles", 32'(en_n), 32'(L));
        chk("addr_stable", 32'(addr_ok), 32'd1);
        chk("ack_owner", 32'(is_mem ? mem_ack_l : if_ack_l), 32'd1);
        chk("ack_other", 32'(is_mem ? if_ack_l : mem_ack_l), 32'd0);
        chk("ram_cleared", {26'd0, ram_en_l, ram_we_l, ram_wmask_l}, 32'd0);
        chk(is_mem ? "mem_rdata" : "if_rdata", is_mem ? mem_rdata_l : if_rdata_l, er);
        if_req_w = 1'b0;
        mem_req_w = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_pulse", {30'd0, if_ack_l, mem_ack_l}, 32'd0);
        chk("back_idle", 32'(arb_busy_l), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        bit          byt;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          pre;
        logic [31:0] pre_val;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [3:0]  em;
        logic [31:0] ew;
        logic [31:0] er;
        bit          g [4];
        int          n;
        int          lows;
        int          acks [$];
        bit          rm, rw, rb;
        logic [31:0] ra, rd;

        tbl[0]  = '{0, 0, 0, 32'h100, 32'h0,        1, 32'h00A00093, 4'h0, 32'h0,        32'h00A00093};
        tbl[1]  = '{1, 0, 0, 32'h202, 32'h0,        1, 32'h12F03456, 4'h0, 32'h0,        32'h12F03456};
        tbl[2]  = '{1, 0, 1, 32'h202, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'hFFFFFFF0};
        tbl[3]  = '{1, 1, 1, 32'h203, 32'h000000AB, 0, 32'h0,        4'h8, 32'hABABABAB, 32'hFFFFFFF0};
        tbl[4]  = '{1, 0, 0, 32'h200, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'hABF03456};
        tbl[5]  = '{1, 1, 0, 32'h204, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF, 32'hABF03456};
        tbl[6]  = '{1, 0, 1, 32'h205, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'hFFFFFFBE};
        tbl[7]  = '{1, 0, 1, 32'h204, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'hFFFFFFEF};
        tbl[8]  = '{1, 0, 1, 32'h201, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h00000034};
        tbl[9]  = '{1, 1, 1, 32'h206, 32'hFFFFFF7F, 0, 32'h0,        4'h4, 32'h7F7F7F7F, 32'h00000034};
        tbl[10] = '{1, 0, 0, 32'h207, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'hDE7FBEEF};
        tbl[11] = '{0, 0, 0, 32'h204, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'hDE7FBEEF};

        for (int i = 0; i < 256; i++) begin
            rmem[i] = $urandom;
            gmem[i] = rmem[i];
        end
        m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
        reset = 1'b1;
        if_req_w = 0; if_addr_w = 0; mem_req_w = 0; mem_we_w = 0; mem_byte_w = 0;
        mem_addr_w = 0; mem_wdata_w = 0;
        d1_if_req = 0; d1_if_addr = 0; d1_mem_req = 0; d1_mem_we = 0; d1_mem_byte = 0;
        d1_mem_addr = 0; d1_mem_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ram_en", {26'd0, ram_en_l, ram_we_l, ram_wmask_l}, 32'd0);
        chk("rst_ram_addr", ram_addr_l, 32'd0);
        chk("rst_ram_wdata", ram_wdata_l, 32'd0);
        chk("rst_acks_busy", {29'd0, if_ack_l, mem_ack_l, arb_busy_l}, 32'd0);
        chk("rst_if_rdata", if_rdata_l, 32'd0);
        chk("rst_mem_rdata", mem_rdata_l, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].pre) begin
                rmem[tbl[i].addr[9:2]] = tbl[i].pre_val;
                gmem[tbl[i].addr[9:2]] = tbl[i].pre_val;
            end
            model_apply(tbl[i].is_mem, tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata, em, ew);
            xact(tbl[i].is_mem, tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata,
                 tbl[i].e_mask, tbl[i].e_wdata, tbl[i].e_rdata);
        end

        // Both ports held for four grants.
        if_req_w = 1'b1; if_addr_w = 32'h104;
        mem_req_w = 1'b1; mem_we_w = 1'b0; mem_byte_w = 1'b0; mem_addr_w = 32'h208;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(posedge clk); #1;
            if (mem_ack_l) begin g[n] = 1'b1; n++; end
            else if (if_ack_l) begin g[n] = 1'b0; n++; end
        end
        @(negedge clk);
        if_req_w = 1'b0; mem_req_w = 1'b0;
        chk("contend_grants", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("contend_grant%0d_is_mem", i), 32'(g[i]), 32'(i % 2 == 0));
`else
            chk($sformatf("contend_grant%0d_is_mem", i), 32'(g[i]), 32'd1);
`endif
            if (!g[i]) m_if_rdata = gmem[8'h41];
        end
        m_mem_rdata = gmem[8'h82];
        chk("contend_mem_rdata", mem_rdata_l, m_mem_rdata);
        chk("contend_if_rdata", if_rdata_l, m_if_rdata);
        @(negedge clk);
        chk("contend_idle", 32'(arb_busy_l), 32'd0);

        // Reset lands in the middle of an access; request stays held.
        mem_req_w = 1'b1; mem_we_w = 1'b0; mem_byte_w = 1'b0; mem_addr_w = 32'h210;
        @(posedge clk); #1;
        chk("abort_started", 32'(ram_en_l), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ram", {26'd0, ram_en_l, ram_we_l, ram_wmask_l}, 32'd0);
        chk("abort_addr", ram_addr_l, 32'd0);
        chk("abort_busy_ack", {29'd0, if_ack_l, mem_ack_l, arb_busy_l}, 32'd0);
        chk("abort_rdata", mem_rdata_l | if_rdata_l, 32'd0);
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_ack_l || if_ack_l) n++;
        end
        chk("abort_no_ack", 32'(n), 32'd0);
        m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        model_apply(1'b1, 1'b0, 1'b0, 32'h210, 32'h0, em, ew);
        xact(1'b1, 1'b0, 1'b0, 32'h210, 32'h0, em, ew, m_mem_rdata);

        for (int i = 0; i < 40; i++) begin
            rm = 1'($urandom_range(0, 1));
            rw = rm & 1'($urandom_range(0, 1));
            rb = rm & 1'($urandom_range(0, 1));
            ra = 32'h200 + 32'($urandom_range(0, 255));
            rd = $urandom;
            model_apply(rm, rw, rb, ra, rd, em, ew);
            er = rm ? m_mem_rdata : m_if_rdata;
            xact(rm, rw, rb, ra, rd, em, ew, er);
        end

        // MEM_LATENCY=1 instance with a fetch held continuously.
        d1_if_addr = 32'h40;
        d1_if_req  = 1'b1;
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (d1_if_ack) acks.push_back(c);
            if (acks.size() == 1 && !d1_busy) lows++;
        end
        d1_if_req = 1'b0;
        chk("lat1_ack_count_ge3", 32'(acks.size() >= 3), 32'd1);
        if (acks.size() >= 3) begin
            chk("lat1_spacing0", 32'(acks[1] - acks[0]), 32'd3);
            chk("lat1_spacing1", 32'(acks[2] - acks[1]), 32'd3);
        end
        chk("lat1_idle_gap", 32'(lows), 32'd1);
        chk("lat1_rdata", d1_if_rdata, 32'hA5A50040);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
